io_hub: RTL and testbench
=========================

# io_hub

Parametrised memory-mapped IO controller: next generation of the fixed 24-bit LED and switch peripherals on the single-cycle CPU. It exposes CH_OUT output banks and CH_IN debounced input banks behind one IO select. It adds per-channel change detection with a write-1-to-clear status register, a maskable interrupt, and per-output blink mode. It sits beside the memory/IO steering logic and consumes its ioRead/ioWrite, IO select, low address bits and write data.

## Interface
- CH_OUT, 3, number of output banks (1..16)
- OUT_W, 8, bits per output bank (1..32)
- CH_IN, 3, number of input banks (1..16)
- IN_W, 8, bits per input bank (1..32)
- DB_CYCLES, 20000, debounce stability count (≥2)
- BLINK_DIV, 12500000, cycles per blink half-period (≥2)
- clock  in  1  CPU clock; all state on rising edge
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
- ioCtrl  in  1  IO select for this block
- ioRead  in  1  read strobe
- ioWrite  in  1  write strobe
- addr  in  8  byte offset within block; addr[1:0] ignored
- write_data  in  32  store data
- read_data  out  32  load data (combinational)
- leds  out  CH_OUT*OUT_W  output banks, bank i at [i*OUT_W +: OUT_W]
- switches  in  CH_IN*IN_W  raw asynchronous inputs, bank j at [j*IN_W +: IN_W]
- irq  out  1  registered interrupt request

## Operation
- Register map:
  - 0x00+4i: OUT[i], R/W, low OUT_W bits.
  - 0x40+4j: IN[j], RO, debounced value.
  - 0x80: PEND[CH_IN-1:0], R/W1C.
  - 0x84: IEN[CH_IN-1:0], R/W.
  - 0x88: BLINK[CH_OUT-1:0], R/W.
- Write: on an edge with ioCtrl&ioWrite=1. Unmapped or out-of-range channel writes are ignored. Upper unused bits are discarded.
- Read:
  - read_data = zero-extended register when ioCtrl&ioRead=1 and the address is mapped.
  - Otherwise read_data = 0.
  - Reads have no side effects.
- Input path: each bit passes a 2-flop synchroniser (s1, s2). Each channel then has a counter cnt and a stable register stb:
  - If s2==stb, cnt←0.
  - Else if cnt==DB_CYCLES-1, stb←s2, cnt←0, PEND[j]←1.
  - Else cnt←cnt+1.
  - A bounce back to stb mid-count restarts the count.
- PEND update: W1C clears written-1 bits. A set and a clear on the same edge → set wins.
- irq ← |(PEND & IEN), registered.
- Blink: a free-running counter bc runs 0..BLINK_DIV-1 and wraps. phase toggles on the wrap. leds bank i = BLINK[i] ? (phase ? OUT[i] : 0) : OUT[i], registered.
- Reset values:
  - OUT, PEND, IEN, BLINK, cnt, bc, phase, irq, leds: 0.
  - s1, s2, stb: 0.
  - read_data follows reset state, so it reads 0.

## Timing
- Write to OUT[i] at edge k → leds bank i changes at edge k+1 (one output register).
- Input change settled before edge k:
  - s2 updates at edge k+1.
  - stb and PEND update at edge k+1+DB_CYCLES.
  - irq asserts at edge k+2+DB_CYCLES.
- Write to IEN/PEND at edge k → irq reflects it at edge k+1.
- Blink: phase high for BLINK_DIV cycles, then low for BLINK_DIV cycles. BLINK change affects leds one edge after the write.
- Load timing: read_data is valid in the same cycle as ioRead, for the single-cycle load path. The value reflects register state before that cycle's edge.
- Reset asserted mid-debounce clears cnt/stb. After release, inputs re-qualify from zero, so a held non-zero input sets PEND after DB_CYCLES+2 edges.

## Structure
- Package io_hub_pkg:
  - Offsets OUT_BASE=8'h00, IN_BASE=8'h40, PEND_OFS=8'h80, IEN_OFS=8'h84, BLINK_OFS=8'h88.
  - Limits MAX_CH=16, MAX_W=32.
- Sub-module io_debounce, instantiated per input channel:
  - Parameters IN_W, DB_CYCLES.
  - Contains the synchroniser, counter and stb.
  - Outputs stb and a one-cycle change pulse.
- Top: register file, address decode, PEND/IEN/irq logic, blink counter, output registers.

## Test plan
Bench parameters: DB_CYCLES=4, BLINK_DIV=3.
- Reset with switches=all ones, then release → all outputs 0 and PEND=0; PEND=0x7 and IN[j]=0xFF exactly 6 edges after release.
- Write 0xA5 to 0x04 → leds[15:8]=0xA5 next edge; read 0x04 → 0x000000A5; read 0x90 → 0.
- Switch bank 1 toggles 0→0x0F, reverts after 3 cycles, then re-applies and holds → first pulse rejected; PEND[1] sets 6 edges after the hold starts; with IEN=0x2, irq rises one edge later.
- W1C of 0x2 on the same edge PEND[1] would set → PEND[1] stays 1; W1C one edge later → PEND[1]=0, irq=0 next edge.
- BLINK=0x1 with OUT[0]=0xFF → leds[7:0] alternates 0x00/0xFF every 3 cycles; banks 1–2 steady.
- Assert reset mid-debounce (cnt=2) → stb and cnt=0 immediately; no PEND until a full re-qualification.

Source files
------------

// File: rtl/io_hub_pkg.sv
// io_hub shared definitions: register offsets, channel/width limits
// and the byte-address to word-index helper.
package io_hub_pkg;

  localparam logic [7:0] OUT_BASE  = 8'h00;
  localparam logic [7:0] IN_BASE   = 8'h40;
  localparam logic [7:0] PEND_OFS  = 8'h80;
  localparam logic [7:0] IEN_OFS   = 8'h84;
  localparam logic [7:0] BLINK_OFS = 8'h88;

  localparam int MAX_CH = 16;
  localparam int MAX_W  = 32;

  function automatic logic [5:0] word_of(
    input logic [7:0] a
  );
    return a[7:2];
  endfunction

endpackage

// File: rtl/io_hub_if.sv
// io_hub CPU-side IO bus: select, read/write strobes, byte address,
// store data (master->slave) and combinational load data (slave->master).
interface io_hub_if;

  logic        ioCtrl;
  logic        ioRead;
  logic        ioWrite;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output ioCtrl, ioRead, ioWrite,
    output addr, write_data,
    input  read_data
  );

  modport slave (
    input  ioCtrl, ioRead, ioWrite,
    input  addr, write_data,
    output read_data
  );

endinterface

// File: rtl/io_debounce.sv
// One input bank: 2-flop sync, stability counter, stable value.
// Ports: clock, reset (async low), i_raw in; o_stb value, o_chg pulse out.
module io_debounce #(
  parameter int IN_W      = 8,
  parameter int DB_CYCLES = 20000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] i_raw,
  output logic [IN_W-1:0] o_stb,
  output logic            o_chg
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [IN_W-1:0] r_s1;
  logic [IN_W-1:0] r_s2;
  logic [IN_W-1:0] r_stb;
  logic [CW-1:0]   r_cnt;
  logic            w_diff;
  logic            w_done;

  assign w_diff = (r_s2 != r_stb);
  // High in the cycle before stb takes the new value, so the
  // pending bit in the parent sets on the same edge as stb.
  assign w_done = w_diff && (r_cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_stb <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      unique case (1'b1)
        !w_diff: r_cnt <= '0;
        w_done: begin
          r_stb <= r_s2;
          r_cnt <= '0;
        end
        default: r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end

  assign o_stb = r_stb;
  assign o_chg = w_done;

endmodule

// File: rtl/io_hub.sv
// Memory-mapped LED/switch hub: output banks with blink, debounced inputs,
// W1C change status, maskable irq. Ports: clock, reset, bus, leds, switches, irq.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int CH_OUT    = 3,
  parameter int OUT_W     = 8,
  parameter int CH_IN     = 3,
  parameter int IN_W      = 8,
  parameter int DB_CYCLES = 20000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                    clock,
  input  logic                    reset,
  io_hub_if.slave                 bus,
  output logic [CH_OUT*OUT_W-1:0] leds,
  input  logic [CH_IN*IN_W-1:0]   switches,
  output logic                    irq
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_DIV - 1);

  logic [OUT_W-1:0]        r_out [CH_OUT];
  logic [CH_IN-1:0]        r_pend;
  logic [CH_IN-1:0]        r_ien;
  logic [CH_OUT-1:0]       r_blink;
  logic [BW-1:0]           r_bc;
  logic                    r_phase;
  logic                    r_irq;
  logic [CH_OUT*OUT_W-1:0] r_leds;

  logic [IN_W-1:0]  w_stb [CH_IN];
  logic [CH_IN-1:0] w_chg;
  logic [CH_IN-1:0] w_clr;
  logic [5:0]       w_word;
  logic [3:0]       w_idx;
  logic             w_out_rgn;
  logic             w_in_rgn;
  logic             w_is_pend;
  logic             w_is_ien;
  logic             w_is_blink;
  logic             w_wr;
  logic             w_rd;
  logic [MAX_W-1:0] w_rdata;
  logic             w_unused;

  for (genvar j = 0; j < CH_IN; j++) begin : g_in
    io_debounce #(
      .IN_W      (IN_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .i_raw (switches[j*IN_W +: IN_W]),
      .o_stb (w_stb[j]),
      .o_chg (w_chg[j])
    );
  end

  assign w_word     = word_of(bus.addr);
  assign w_idx      = w_word[3:0];
  assign w_out_rgn  = (w_word[5:4] == OUT_BASE[7:6]);
  assign w_in_rgn   = (w_word[5:4] == IN_BASE[7:6]);
  assign w_is_pend  = (w_word == word_of(PEND_OFS));
  assign w_is_ien   = (w_word == word_of(IEN_OFS));
  assign w_is_blink = (w_word == word_of(BLINK_OFS));
  assign w_wr       = bus.ioCtrl & bus.ioWrite;
  assign w_rd       = bus.ioCtrl & bus.ioRead;
  assign w_clr      = (w_wr && w_is_pend) ? bus.write_data[CH_IN-1:0] : '0;
  assign w_unused   = ^{bus.addr[1:0], bus.write_data};

  // Channel indices past CH_OUT/CH_IN match no loop iteration,
  // so they read as zero and writes to them fall away.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      for (int i = 0; i < CH_OUT; i++)
        if (w_out_rgn && w_idx == 4'(i))
          w_rdata[OUT_W-1:0] = r_out[i];
      for (int j = 0; j < CH_IN; j++)
        if (w_in_rgn && w_idx == 4'(j))
          w_rdata[IN_W-1:0] = w_stb[j];
      if (w_is_pend)  w_rdata[CH_IN-1:0]  = r_pend;
      if (w_is_ien)   w_rdata[CH_IN-1:0]  = r_ien;
      if (w_is_blink) w_rdata[CH_OUT-1:0] = r_blink;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH_OUT; i++) r_out[i] <= '0;
      r_pend  <= '0;
      r_ien   <= '0;
      r_blink <= '0;
      r_irq   <= 1'b0;
    end else begin
      for (int i = 0; i < CH_OUT; i++)
        if (w_wr && w_out_rgn && w_idx == 4'(i))
          r_out[i] <= bus.write_data[OUT_W-1:0];
      if (w_wr) begin
        unique case (1'b1)
          w_is_ien:   r_ien   <= bus.write_data[CH_IN-1:0];
          w_is_blink: r_blink <= bus.write_data[CH_OUT-1:0];
          default: ;
        endcase
      end
      // A fresh change beats a same-edge clear.
      r_pend <= (r_pend & ~w_clr) | w_chg;
      r_irq  <= |(r_pend & r_ien);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bc    <= '0;
      r_phase <= 1'b0;
      r_leds  <= '0;
    end else begin
      if (r_bc == BC_LAST) begin
        r_bc    <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bc <= r_bc + 1'b1;
      end
      for (int i = 0; i < CH_OUT; i++)
        r_leds[i*OUT_W +: OUT_W] <=
          (r_blink[i] && !r_phase) ? '0 : r_out[i];
    end
  end

  assign bus.read_data = w_rdata;
  assign leds          = r_leds;
  assign irq           = r_irq;

endmodule

// File: tb/tb_io_hub.sv
// Scoreboard bench for io_hub: directed bus/switch stimulus pushes
// expected values, a negedge monitor pops and compares them.
module tb_io_hub;
  import io_hub_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] leds;
  logic [23:0] switches;
  logic        irq;

  io_hub_if bus();

  io_hub #(
    .CH_OUT    (3),
    .OUT_W     (8),
    .CH_IN     (3),
    .IN_W      (8),
    .DB_CYCLES (4),
    .BLINK_DIV (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .leds     (leds),
    .switches (switches),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum {S_RD, S_LED, S_IRQ} sel_e;
  typedef struct {
    int          at;
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int errs   = 0;
  int checks = 0;
  int rel    = 0;

  function automatic void expect_at(int at, sel_e s,
                                    logic [31:0] e, string n);
    exp_t x;
    x.at = at; x.sel = s; x.exp = e; x.name = n;
    q.push_back(x);
  endfunction

  always @(negedge clock) begin : mon
    logic [31:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        case (q[i].sel)
          S_RD:    act = bus.read_data;
          S_LED:   act = {8'h00, leds};
          default: act = {31'h0, irq};
        endcase
        checks++;
        if (q[i].at < cyc || act !== q[i].exp) begin
          errs++;
          $display("FAIL %s: got %h expected %h (cycle %0d)",
                   q[i].name, act, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick(1);
  endtask

  task automatic bus_op(bit rd, bit wr, logic [7:0] a,
                        logic [31:0] wd, logic [31:0] e, string n);
    bus.ioCtrl     = 1'b1;
    bus.ioRead     = rd;
    bus.ioWrite    = wr;
    bus.addr       = a;
    bus.write_data = wd;
    if (rd) expect_at(cyc, S_RD, e, n);
    tick(1);
    bus.ioCtrl  = 1'b0;
    bus.ioRead  = 1'b0;
    bus.ioWrite = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    bus_op(1'b0, 1'b1, a, d, 32'h0, "");
  endtask

  task automatic rd(logic [7:0] a, logic [31:0] e, string n);
    bus_op(1'b1, 1'b0, a, 32'h0, e, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, b0, m0, nn;
    logic [31:0] e;
    bus.ioCtrl     = 1'b0;
    bus.ioRead     = 1'b0;
    bus.ioWrite    = 1'b0;
    bus.addr       = 8'h00;
    bus.write_data = 32'h0;
    switches       = 24'hFFFFFF;
    reset          = 1'b0;

    tick(2);
    checks++;
    if (leds !== 24'h0) begin
      errs++;
      $display("FAIL rst_leds_now: got %h expected 000000", leds);
    end
    checks++;
    if (irq !== 1'b0) begin
      errs++;
      $display("FAIL rst_irq_now: got %b expected 0", irq);
    end
    expect_at(cyc, S_LED, 32'h0, "rst_leds");
    expect_at(cyc, S_IRQ, 32'h0, "rst_irq");
    rd(PEND_OFS, 32'h0, "rst_pend");
    rd(8'h40, 32'h0, "rst_in0");
    reset = 1'b1;
    rel   = cyc;
    expect_at(rel, S_LED, 32'h0, "rel_leds");
    wait_cyc(rel + 5);
    rd(PEND_OFS, 32'h0, "pend_edge5");
    rd(PEND_OFS, 32'h7, "pend_edge6");
    rd(8'h40, 32'hFF, "in0_ff");
    rd(8'h48, 32'hFF, "in2_ff");
    expect_at(cyc, S_IRQ, 32'h0, "irq_masked");

    expect_at(cyc + 1, S_LED, 32'h0, "leds_not_yet");
    expect_at(cyc + 2, S_LED, 32'h00A500, "leds_a5");
    wr(8'h04, 32'hA5);
    rd(8'h04, 32'hA5, "rd_out1");
    rd(8'h90, 32'h0, "rd_unmapped");
    wr(8'h08, 32'hFFFFFF3C);
    rd(8'h08, 32'h3C, "rd_trunc");
    wr(8'h0C, 32'h77);
    rd(8'h0C, 32'h0, "rd_oob");
    expect_at(cyc, S_LED, 32'h3CA500, "leds_oob");

    switches[15:8] = 8'h00;
    tick(12);
    wr(PEND_OFS, 32'h7);
    rd(PEND_OFS, 32'h0, "pend_clr");
    wr(IEN_OFS, 32'h2);
    rd(IEN_OFS, 32'h2, "rd_ien");
    t0 = cyc;
    switches[15:8] = 8'h0F;
    tick(3);
    switches[15:8] = 8'h00;
    wait_cyc(t0 + 7);
    rd(PEND_OFS, 32'h0, "glitch_rej");
    t1 = cyc;
    switches[15:8] = 8'h0F;
    expect_at(t1 + 6, S_IRQ, 32'h0, "irq_pre");
    expect_at(t1 + 7, S_IRQ, 32'h1, "irq_set");
    expect_at(t1 + 8, S_IRQ, 32'h0, "irq_clr");
    wait_cyc(t1 + 5);
    bus_op(1'b1, 1'b1, PEND_OFS, 32'h2, 32'h0, "pend_pre");
    bus_op(1'b1, 1'b1, PEND_OFS, 32'h2, 32'h2, "pend_setwins");
    rd(PEND_OFS, 32'h0, "pend_w1c");
    rd(8'h44, 32'h0F, "in1_0f");

    b0 = cyc;
    wr(8'h00, 32'hFF);
    wr(BLINK_OFS, 32'h1);
    expect_at(b0 + 2, S_LED, 32'h3CA5FF, "blink_pre");
    for (int c = b0 + 3; c <= b0 + 14; c++) begin
      nn = c - rel;
      e  = (((nn - 1) / 3) % 2 != 0) ? 32'h3CA5FF : 32'h3CA500;
      expect_at(c, S_LED, e, "blink");
    end
    rd(BLINK_OFS, 32'h1, "rd_blink");
    tick(13);

    m0 = cyc;
    switches[23:16] = 8'h55;
    wait_cyc(m0 + 4);
    reset = 1'b0;
    #1;
    checks++;
    if (leds !== 24'h0) begin
      errs++;
      $display("FAIL rst2_leds_now: got %h expected 000000", leds);
    end
    checks++;
    if (irq !== 1'b0) begin
      errs++;
      $display("FAIL rst2_irq_now: got %b expected 0", irq);
    end
    expect_at(cyc, S_LED, 32'h0, "rst2_leds");
    expect_at(cyc, S_IRQ, 32'h0, "rst2_irq");
    rd(8'h48, 32'h0, "rst2_in2");
    rd(PEND_OFS, 32'h0, "rst2_pend");
    reset = 1'b1;
    rel   = cyc;
    wait_cyc(rel + 5);
    rd(PEND_OFS, 32'h0, "requal_edge5");
    rd(PEND_OFS, 32'h7, "requal_edge6");
    rd(8'h48, 32'h55, "in2_55");
    rd(8'h00, 32'h0, "rst2_out0");
    expect_at(cyc, S_IRQ, 32'h0, "rst2_irq_off");

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    foreach (q[i]) begin
      checks++;
      errs++;
      $display("FAIL %s: got none expected %h (never checked)",
               q[i].name, q[i].exp);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
